// File: rtl/mailbox_fifo_unit.sv
// Mailbox FIFO unit: NumMbox register-bus mailboxes, each holding a message FIFO
// with sticky overflow/underflow flags and watermark-driven level interrupts.

package mailbox_fifo_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module mailbox_fifo_unit #(
    parameter type         reg_req_t = mailbox_fifo_pkg::reg_req_t,
    parameter type         reg_rsp_t = mailbox_fifo_pkg::reg_rsp_t,
    parameter int unsigned NumMbox   = 4,
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  reg_req_t           reg_req_i,
    output reg_rsp_t           reg_rsp_o,
    output logic [NumMbox-1:0] snd_irq_o,
    output logic [NumMbox-1:0] rcv_irq_o
);

    localparam int unsigned IdxW = (NumMbox > 1) ? $clog2(NumMbox) : 1;
    localparam int unsigned IdxD = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    localparam logic [7:0] OffWdata  = 8'h00;
    localparam logic [7:0] OffRdata  = 8'h04;
    localparam logic [7:0] OffStatus = 8'h08;
    localparam logic [7:0] OffErrclr = 8'h0C;
    localparam logic [7:0] OffRcvthr = 8'h10;
    localparam logic [7:0] OffSndthr = 8'h14;
    localparam logic [7:0] OffIrqen  = 8'h18;
    localparam logic [7:0] OffFlush  = 8'h1C;

    // Message storage: data only, never reset (pointers define validity)
    logic [DataWidth-1:0] mem_q [NumMbox][Depth];

    // Per-mailbox control state
    logic [IdxD-1:0] wr_ptr_q [NumMbox];
    logic [IdxD-1:0] wr_ptr_d [NumMbox];
    logic [IdxD-1:0] rd_ptr_q [NumMbox];
    logic [IdxD-1:0] rd_ptr_d [NumMbox];
    logic [CntW-1:0] count_q  [NumMbox];
    logic [CntW-1:0] count_d  [NumMbox];
    logic [CntW-1:0] rcvthr_q [NumMbox];
    logic [CntW-1:0] rcvthr_d [NumMbox];
    logic [CntW-1:0] sndthr_q [NumMbox];
    logic [CntW-1:0] sndthr_d [NumMbox];
    logic [1:0]      irqen_q  [NumMbox];
    logic [1:0]      irqen_d  [NumMbox];
    logic            ovf_q    [NumMbox];
    logic            ovf_d    [NumMbox];
    logic            udf_q    [NumMbox];
    logic            udf_d    [NumMbox];

    logic [NumMbox-1:0] snd_irq_q;
    logic [NumMbox-1:0] snd_irq_d;
    logic [NumMbox-1:0] rcv_irq_q;
    logic [NumMbox-1:0] rcv_irq_d;

    // Decoded access
    logic [23:0]     mbox_num;
    logic [7:0]      offset;
    logic [IdxW-1:0] idx;
    logic            idx_ok;
    logic [CntW-1:0] sel_count;

    logic       push_en;
    logic       pop_en;
    logic       flush_en;
    logic       ovf_set;
    logic       udf_set;
    logic [1:0] errclr;
    logic       rcvthr_we;
    logic       sndthr_we;
    logic       irqen_we;

    reg_rsp_t rsp;

    // Write data bits beyond DataWidth/CntW are intentionally ignored
    logic unused_wdata;
    assign unused_wdata = ^reg_req_i.wdata;

    // Every address bit above the 256 B window selects the mailbox, so
    // aliases beyond NumMbox are rejected rather than folded back.
    assign mbox_num  = reg_req_i.addr[31:8];
    assign offset    = reg_req_i.addr[7:0];
    assign idx       = reg_req_i.addr[8 +: IdxW];
    assign idx_ok    = 32'(mbox_num) < NumMbox;
    assign sel_count = count_q[idx];

    // Register decode and combinational response; one access per cycle
    always_comb begin
        rsp       = '0;
        rsp.ready = 1'b1;
        push_en   = 1'b0;
        pop_en    = 1'b0;
        flush_en  = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        errclr    = 2'b00;
        rcvthr_we = 1'b0;
        sndthr_we = 1'b0;
        irqen_we  = 1'b0;
        if (reg_req_i.valid) begin
            if (!idx_ok) begin
                rsp.error = 1'b1;
            end else begin
                case (offset)
                    OffWdata: begin
                        if (reg_req_i.write) begin
                            if (reg_req_i.wstrb != '1) begin
                                rsp.error = 1'b1;
                            end else if (sel_count == FullCnt) begin
                                rsp.error = 1'b1;
                                ovf_set   = 1'b1;
                            end else begin
                                push_en = 1'b1;
                            end
                        end
                    end
                    OffRdata: begin
                        if (reg_req_i.write) begin
                            rsp.error = 1'b1;
                        end else if (sel_count == '0) begin
                            rsp.error = 1'b1;
                            udf_set   = 1'b1;
                        end else begin
                            pop_en                    = 1'b1;
                            rsp.rdata[DataWidth-1:0] = mem_q[idx][rd_ptr_q[idx]];
                        end
                    end
                    OffStatus: begin
                        if (!reg_req_i.write) begin
                            rsp.rdata[CntW-1:0] = sel_count;
                            rsp.rdata[16]       = (sel_count == '0);
                            rsp.rdata[17]       = (sel_count == FullCnt);
                            rsp.rdata[18]       = ovf_q[idx];
                            rsp.rdata[19]       = udf_q[idx];
                        end
                    end
                    OffErrclr: begin
                        if (reg_req_i.write) begin
                            errclr = reg_req_i.wdata[1:0];
                        end
                    end
                    OffRcvthr: begin
                        if (reg_req_i.write) begin
                            rcvthr_we = 1'b1;
                        end else begin
                            rsp.rdata[CntW-1:0] = rcvthr_q[idx];
                        end
                    end
                    OffSndthr: begin
                        if (reg_req_i.write) begin
                            sndthr_we = 1'b1;
                        end else begin
                            rsp.rdata[CntW-1:0] = sndthr_q[idx];
                        end
                    end
                    OffIrqen: begin
                        if (reg_req_i.write) begin
                            irqen_we = 1'b1;
                        end else begin
                            rsp.rdata[1:0] = irqen_q[idx];
                        end
                    end
                    OffFlush: begin
                        if (reg_req_i.write) begin
                            flush_en = reg_req_i.wdata[0];
                        end
                    end
                    default: begin
                        rsp.error = 1'b1;
                    end
                endcase
            end
        end
    end

    assign reg_rsp_o = rsp;

    // Next-state for the addressed mailbox; all others hold
    always_comb begin
        for (int i = 0; i < int'(NumMbox); i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            rcvthr_d[i] = rcvthr_q[i];
            sndthr_d[i] = sndthr_q[i];
            irqen_d[i]  = irqen_q[i];
            ovf_d[i]    = ovf_q[i];
            udf_d[i]    = udf_q[i];
        end
        if (push_en) begin
            wr_ptr_d[idx] = wr_ptr_q[idx] + 1'b1;
            count_d[idx]  = count_q[idx] + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d[idx] = rd_ptr_q[idx] + 1'b1;
            count_d[idx]  = count_q[idx] - 1'b1;
        end
        if (flush_en) begin
            wr_ptr_d[idx] = '0;
            rd_ptr_d[idx] = '0;
            count_d[idx]  = '0;
        end
        if (ovf_set) begin
            ovf_d[idx] = 1'b1;
        end
        if (udf_set) begin
            udf_d[idx] = 1'b1;
        end
        if (errclr[0]) begin
            ovf_d[idx] = 1'b0;
        end
        if (errclr[1]) begin
            udf_d[idx] = 1'b0;
        end
        if (rcvthr_we) begin
            rcvthr_d[idx] = reg_req_i.wdata[CntW-1:0];
        end
        if (sndthr_we) begin
            sndthr_d[idx] = reg_req_i.wdata[CntW-1:0];
        end
        if (irqen_we) begin
            irqen_d[idx] = reg_req_i.wdata[1:0];
        end
    end

    // Level interrupts from the current (pre-edge) fill level and thresholds
    always_comb begin
        snd_irq_d = '0;
        rcv_irq_d = '0;
        for (int i = 0; i < int'(NumMbox); i++) begin
            snd_irq_d[i] = irqen_q[i][1] & (count_q[i] <= sndthr_q[i]);
            rcv_irq_d[i] = irqen_q[i][0] & (rcvthr_q[i] != '0) &
                           (count_q[i] >= rcvthr_q[i]);
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumMbox); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                rcvthr_q[i] <= CntW'(1);
                sndthr_q[i] <= '0;
                irqen_q[i]  <= 2'b00;
                ovf_q[i]    <= 1'b0;
                udf_q[i]    <= 1'b0;
            end
            snd_irq_q <= '0;
            rcv_irq_q <= '0;
        end else begin
            for (int i = 0; i < int'(NumMbox); i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
                rcvthr_q[i] <= rcvthr_d[i];
                sndthr_q[i] <= sndthr_d[i];
                irqen_q[i]  <= irqen_d[i];
                ovf_q[i]    <= ovf_d[i];
                udf_q[i]    <= udf_d[i];
            end
            snd_irq_q <= snd_irq_d;
            rcv_irq_q <= rcv_irq_d;
        end
    end

    // Message storage write on accepted push
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[idx][wr_ptr_q[idx]] <= reg_req_i.wdata[DataWidth-1:0];
        end
    end

    assign snd_irq_o = snd_irq_q;
    assign rcv_irq_o = rcv_irq_q;

endmodule

// File: tb/tb_mailbox_fifo_unit.sv
// Scoreboard bench for mailbox_fifo_unit: directed scenarios then random traffic,
// compared against a queue-based reference model of the mailbox rules.

module tb_mailbox_fifo_unit;

    localparam int NM    = 4;
    localparam int DEPTH = 4;
    localparam int CMASK = 7;

    logic clk;
    logic rst;
    mailbox_fifo_pkg::reg_req_t req;
    mailbox_fifo_pkg::reg_rsp_t rsp;
    logic [NM-1:0] snd_irq;
    logic [NM-1:0] rcv_irq;

    mailbox_fifo_unit #(
        .NumMbox  (NM),
        .Depth    (DEPTH),
        .DataWidth(32)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .reg_req_i(req),
        .reg_rsp_o(rsp),
        .snd_irq_o(snd_irq),
        .rcv_irq_o(rcv_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0: no rsp check, 1: idle rsp, 2: access rsp
        logic [31:0] rdata;
        bit          err;
        logic [NM-1:0] snd;
        logic [NM-1:0] rcv;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_fifo [NM][$];
    int          m_rcvthr [NM];
    int          m_sndthr [NM];
    int          m_irqen  [NM];
    bit          m_ovf    [NM];
    bit          m_udf    [NM];
    logic [NM-1:0] m_snd;
    logic [NM-1:0] m_rcv;

    function automatic void m_reset();
        for (int i = 0; i < NM; i++) begin
            m_fifo[i].delete();
            m_rcvthr[i] = 1;
            m_sndthr[i] = 0;
            m_irqen[i]  = 0;
            m_ovf[i]    = 1'b0;
            m_udf[i]    = 1'b0;
        end
    endfunction

    function automatic void m_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] s, output logic [31:0] rd, output bit er);
        int mb;
        int off;
        int sz;
        mb  = int'(a >> 8);
        off = int'(a & 32'hFF);
        rd  = '0;
        er  = 1'b0;
        if (mb >= NM) begin
            er = 1'b1;
        end else begin
            sz = m_fifo[mb].size();
            case (off)
                'h00: if (w) begin
                    if (s != 4'hF) er = 1'b1;
                    else if (sz == DEPTH) begin er = 1'b1; m_ovf[mb] = 1'b1; end
                    else m_fifo[mb].push_back(d);
                end
                'h04: begin
                    if (w) er = 1'b1;
                    else if (sz == 0) begin er = 1'b1; m_udf[mb] = 1'b1; end
                    else rd = m_fifo[mb].pop_front();
                end
                'h08: if (!w) begin
                    rd = 32'(sz);
                    rd[16] = (sz == 0);
                    rd[17] = (sz == DEPTH);
                    rd[18] = m_ovf[mb];
                    rd[19] = m_udf[mb];
                end
                'h0C: if (w) begin
                    if (d[0]) m_ovf[mb] = 1'b0;
                    if (d[1]) m_udf[mb] = 1'b0;
                end
                'h10: if (w) m_rcvthr[mb] = int'(d) & CMASK; else rd = 32'(m_rcvthr[mb]);
                'h14: if (w) m_sndthr[mb] = int'(d) & CMASK; else rd = 32'(m_sndthr[mb]);
                'h18: if (w) m_irqen[mb] = int'(d) & 3; else rd = 32'(m_irqen[mb]);
                'h1C: if (w && d[0]) m_fifo[mb].delete();
                default: er = 1'b1;
            endcase
        end
    endfunction

    task automatic step(input bit r, input bit v, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        logic [NM-1:0] nsnd;
        logic [NM-1:0] nrcv;
        int sz;
        @(posedge clk);
        #1;
        rst       = r;
        req.valid = v;
        req.write = w;
        req.addr  = a;
        req.wdata = d;
        req.wstrb = s;
        e.kind  = r ? 0 : (v ? 2 : 1);
        e.rdata = '0;
        e.err   = 1'b0;
        e.snd   = m_snd;
        e.rcv   = m_rcv;
        for (int i = 0; i < NM; i++) begin
            sz = m_fifo[i].size();
            nsnd[i] = m_irqen[i][1] && (sz <= m_sndthr[i]);
            nrcv[i] = m_irqen[i][0] && (m_rcvthr[i] != 0) && (sz >= m_rcvthr[i]);
        end
        if (r) begin
            m_reset();
            nsnd = '0;
            nrcv = '0;
        end else if (v) begin
            m_access(w, a, d, s, e.rdata, e.err);
        end
        m_snd = nsnd;
        m_rcv = nrcv;
        expq.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, a, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Monitor: pop one expectation per cycle and compare mid-cycle
    exp_t me;
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            if (me.kind != 0) begin
                checks++;
                if (rsp.ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready got=%0b exp=1", rsp.ready);
                end
                checks++;
                if (rsp.error !== me.err) begin
                    errors++;
                    $display("FAIL error addr=%0h got=%0b exp=%0b", req.addr, rsp.error, me.err);
                end
                checks++;
                if (rsp.rdata !== me.rdata) begin
                    errors++;
                    $display("FAIL rdata addr=%0h got=%0h exp=%0h", req.addr, rsp.rdata, me.rdata);
                end
            end
            checks++;
            if (snd_irq !== me.snd) begin
                errors++;
                $display("FAIL snd_irq got=%0b exp=%0b", snd_irq, me.snd);
            end
            checks++;
            if (rcv_irq !== me.rcv) begin
                errors++;
                $display("FAIL rcv_irq got=%0b exp=%0b", rcv_irq, me.rcv);
            end
        end
    end

    initial begin
        int op;
        int mb;
        logic [31:0] base;
        logic [31:0] dat;
        rst = 1'b1;
        req = '0;
        m_reset();
        m_snd = '0;
        m_rcv = '0;

        // Push/pop order and underflow on mailbox 1
        rd(32'h110);
        rd(32'h114);
        rd(32'h108);
        wr(32'h100, 32'hA);
        wr(32'h100, 32'hB);
        wr(32'h100, 32'hC);
        rd(32'h108);
        for (int i = 0; i < 4; i++) rd(32'h104);
        rd(32'h108);

        // Overflow, error clear, wrap-around on mailbox 0
        for (int i = 0; i < 5; i++) wr(32'h000, 32'h10 + i);
        rd(32'h008);
        wr(32'h00C, 32'h1);
        rd(32'h008);
        rd(32'h004);
        wr(32'h000, 32'h55);
        for (int i = 0; i < 4; i++) rd(32'h004);
        rd(32'h008);

        // Receive watermark on mailbox 2
        wr(32'h218, 32'h1);
        wr(32'h210, 32'h2);
        wr(32'h200, 32'h1);
        idle(2);
        wr(32'h200, 32'h2);
        idle(2);
        rd(32'h204);
        idle(2);

        // Send watermark on mailbox 3
        wr(32'h318, 32'h2);
        wr(32'h314, 32'h1);
        idle(2);
        wr(32'h300, 32'h7);
        wr(32'h300, 32'h8);
        idle(2);
        rd(32'h304);
        idle(2);

        // Decode errors and partial strobes
        rd(32'h400);
        wr(32'h400, 32'h1);
        rd(32'h020);
        rd(32'h002);
        step(1'b0, 1'b1, 1'b1, 32'h000, 32'h99, 4'h3);
        rd(32'h008);
        wr(32'h104, 32'h1);

        // Flush with interrupts enabled, then reset mid-burst
        wr(32'h118, 32'h3);
        for (int i = 0; i < 3; i++) wr(32'h100, 32'h20 + i);
        idle(2);
        wr(32'h11C, 32'h1);
        idle(2);
        rd(32'h108);
        wr(32'h100, 32'h30);
        wr(32'h100, 32'h31);
        step(1'b1, 1'b1, 1'b1, 32'h100, 32'h32, 4'hF);
        idle(1);
        rd(32'h108);
        rd(32'h110);
        rd(32'h114);
        rd(32'h118);
        rd(32'h104);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            mb   = ($urandom_range(0, 24) == 0) ? NM : int'($urandom_range(0, NM - 1));
            base = 32'(mb) << 8;
            op   = int'($urandom_range(0, 19));
            dat  = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end else if (op < 7) begin
                step(1'b0, 1'b1, 1'b1, base, dat,
                     ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 14)) : 4'hF);
            end else if (op < 12) begin
                rd(base + 32'h04);
            end else if (op == 12) begin
                rd(base + 32'h08);
            end else if (op == 13) begin
                wr(base + 32'h0C, 32'($urandom_range(0, 3)));
            end else if (op == 14) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), base + 32'h10, 32'($urandom_range(0, 7)), 4'hF);
            end else if (op == 15) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), base + 32'h14, 32'($urandom_range(0, 7)), 4'hF);
            end else if (op == 16) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), base + 32'h18, 32'($urandom_range(0, 3)), 4'hF);
            end else if (op == 17) begin
                if ($urandom_range(0, 3) == 0) wr(base + 32'h1C, 32'($urandom_range(0, 1)));
                else idle(1);
            end else if (op == 18) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), base + 32'($urandom_range(32, 255)), dat, 4'hF);
            end else begin
                idle(1);
            end
        end
        idle(2);
        @(negedge clk);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
